// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes RISC-V ALU/branch fields into the ALU select
// code, drives registered operands into a combinational ALU, and holds the
// captured result on a valid/ready output handshake.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no op in flight; ready to accept
// ISSUE | operands on the ALU; result captured at the end of the cycle
// HOLD  | result presented; waits for out_ready, can accept the next op
module alu_issue_ctrl #(
   parameter int DATA_W = 33,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        opcode,
   input  logic [2:0]        funct3,
   input  logic              funct7_5,
   input  logic [DATA_W-1:0] rs1_val,
   input  logic [DATA_W-1:0] rs2_val,
   input  logic [DATA_W-1:0] imm_val,
   output logic [DATA_W-1:0] ALU_A,
   output logic [DATA_W-1:0] ALU_B,
   output logic [3:0]        ALU_Sel,
   input  logic [DATA_W-1:0] ALU_Result,
   input  logic              ALU_Zero,
   input  logic              ALU_Carry,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              out_zero,
   output logic              out_carry,
   output logic              out_taken,
   output logic              out_illegal,
   output logic [CNT_W-1:0]  op_count
);

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;

   localparam logic [3:0] SEL_AND = 4'b0000;
   localparam logic [3:0] SEL_OR  = 4'b0001;
   localparam logic [3:0] SEL_ADD = 4'b0010;
   localparam logic [3:0] SEL_NOP = 4'b0011;
   localparam logic [3:0] SEL_SUB = 4'b0110;
   localparam logic [3:0] SEL_SLT = 4'b0111;
   localparam logic [3:0] SEL_EQ  = 4'b1111;

   localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_HOLD} state_t;

   state_t r_state, w_state_nxt;

   logic              w_in_ready;
   logic              w_accept;
   logic [3:0]        w_sel;
   logic              w_use_imm;
   logic              w_branch;
   logic              w_taken_inv;
   logic              w_illegal;
   logic [DATA_W-1:0] w_flip;
   logic [DATA_W-1:0] w_opnd_b;
   logic [DATA_W-1:0] w_alu_a;
   logic [DATA_W-1:0] w_alu_b;

   logic [DATA_W-1:0] r_alu_a;
   logic [DATA_W-1:0] r_alu_b;
   logic [3:0]        r_alu_sel;
   logic              r_branch;
   logic              r_taken_inv;
   logic              r_illegal;
   logic [CNT_W-1:0]  r_op_count;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_result;
   logic              r_out_zero;
   logic              r_out_carry;
   logic              r_out_taken;
   logic              r_out_illegal;

   // Instruction decode into select code and branch/illegal attributes
   always_comb begin
      w_sel       = SEL_NOP;
      w_use_imm   = 1'b0;
      w_branch    = 1'b0;
      w_taken_inv = 1'b0;
      w_illegal   = 1'b1;
      case (opcode)
         OP_R: begin
            w_illegal = 1'b0;
            case (funct3)
               3'b000:  w_sel = funct7_5 ? SEL_SUB : SEL_ADD;
               3'b111:  w_sel = SEL_AND;
               3'b110:  w_sel = SEL_OR;
               3'b010:  w_sel = SEL_SLT;
               default: w_illegal = 1'b1;
            endcase
         end
         OP_I: begin
            w_illegal = 1'b0;
            w_use_imm = 1'b1;
            case (funct3)
               3'b000:  w_sel = SEL_ADD;
               3'b111:  w_sel = SEL_AND;
               3'b110:  w_sel = SEL_OR;
               3'b010:  w_sel = SEL_SLT;
               default: w_illegal = 1'b1;
            endcase
         end
         OP_BR: begin
            w_illegal = 1'b0;
            w_branch  = 1'b1;
            case (funct3)
               3'b000:  w_sel = SEL_EQ;
               3'b001: begin
                  w_sel       = SEL_EQ;
                  w_taken_inv = 1'b1;
               end
               3'b100:  w_sel = SEL_SLT;
               3'b101: begin
                  w_sel       = SEL_SLT;
                  w_taken_inv = 1'b1;
               end
               default: w_illegal = 1'b1;
            endcase
         end
         default: w_illegal = 1'b1;
      endcase
      if (w_illegal) begin
         w_sel       = SEL_NOP;
         w_branch    = 1'b0;
         w_taken_inv = 1'b0;
      end
   end

   // Offset-binary both operands for compares so the unsigned ALU compare is signed
   assign w_flip   = (w_sel == SEL_SLT) ? MSB_MASK : '0;
   assign w_opnd_b = w_use_imm ? imm_val : rs2_val;
   assign w_alu_a  = w_illegal ? '0 : (rs1_val ^ w_flip);
   assign w_alu_b  = w_illegal ? '0 : (w_opnd_b ^ w_flip);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and input-side ready
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_in_ready = 1'b1;
            if (in_valid) w_state_nxt = ST_ISSUE;
         end
         ST_ISSUE: w_state_nxt = ST_HOLD;
         ST_HOLD: begin
            w_in_ready = out_ready;
            if (out_ready) w_state_nxt = in_valid ? ST_ISSUE : ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_accept = in_valid & w_in_ready;

   // Latch decoded operands and attributes on acceptance; count accepted ops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_sel   <= '0;
         r_branch    <= 1'b0;
         r_taken_inv <= 1'b0;
         r_illegal   <= 1'b0;
         r_op_count  <= '0;
      end else if (w_accept) begin
         r_alu_a     <= w_alu_a;
         r_alu_b     <= w_alu_b;
         r_alu_sel   <= w_sel;
         r_branch    <= w_branch;
         r_taken_inv <= w_taken_inv;
         r_illegal   <= w_illegal;
         r_op_count  <= r_op_count + CNT_ONE;
      end
   end

   // Capture ALU outputs at the end of ISSUE; drop valid when the consumer takes it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid   <= 1'b0;
         r_out_result  <= '0;
         r_out_zero    <= 1'b0;
         r_out_carry   <= 1'b0;
         r_out_taken   <= 1'b0;
         r_out_illegal <= 1'b0;
      end else if (r_state == ST_ISSUE) begin
         r_out_valid   <= 1'b1;
         r_out_result  <= r_illegal ? '0 : ALU_Result;
         r_out_zero    <= r_illegal ? 1'b1 : ALU_Zero;
         r_out_carry   <= r_illegal ? 1'b0 : ALU_Carry;
         r_out_taken   <= r_branch & (ALU_Result[0] ^ r_taken_inv);
         r_out_illegal <= r_illegal;
      end else if ((r_state == ST_HOLD) && out_ready) begin
         r_out_valid   <= 1'b0;
      end
   end

   assign in_ready    = w_in_ready;
   assign ALU_A       = r_alu_a;
   assign ALU_B       = r_alu_b;
   assign ALU_Sel     = r_alu_sel;
   assign out_valid   = r_out_valid;
   assign out_result  = r_out_result;
   assign out_zero    = r_out_zero;
   assign out_carry   = r_out_carry;
   assign out_taken   = r_out_taken;
   assign out_illegal = r_out_illegal;
   assign op_count    = r_op_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a combinational ALU stand-in, directed reset
// checks, then a cycle-by-cycle comparison against a behavioural model.
module tb_alu_issue_ctrl;

   localparam int DW = 33;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [6:0]    opcode;
   logic [2:0]    funct3;
   logic          funct7_5;
   logic [DW-1:0] rs1_val, rs2_val, imm_val;
   logic [DW-1:0] ALU_A, ALU_B;
   logic [3:0]    ALU_Sel;
   logic [DW-1:0] ALU_Result;
   logic          ALU_Zero, ALU_Carry;
   logic          out_valid, out_ready;
   logic [DW-1:0] out_result;
   logic          out_zero, out_carry, out_taken, out_illegal;
   logic [15:0]   op_count;

   always #5 clk = ~clk;

   alu_issue_ctrl dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .rs1_val(rs1_val), .rs2_val(rs2_val), .imm_val(imm_val),
      .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Sel(ALU_Sel),
      .ALU_Result(ALU_Result), .ALU_Zero(ALU_Zero), .ALU_Carry(ALU_Carry),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_zero(out_zero), .out_carry(out_carry), .out_taken(out_taken),
      .out_illegal(out_illegal), .op_count(op_count)
   );

   // ALU stand-in: unsigned compare, equality as 1111, junk for unused codes
   logic [DW:0] alu_sum;
   always_comb begin
      alu_sum    = {1'b0, ALU_A} + {1'b0, ALU_B};
      ALU_Result = 33'h1_5A5A_5A5A;
      ALU_Carry  = 1'b1;
      case (ALU_Sel)
         4'b0000: begin ALU_Result = ALU_A & ALU_B; ALU_Carry = 1'b0; end
         4'b0001: begin ALU_Result = ALU_A | ALU_B; ALU_Carry = 1'b0; end
         4'b0010: begin ALU_Result = alu_sum[DW-1:0]; ALU_Carry = alu_sum[DW]; end
         4'b0110: begin ALU_Result = ALU_A - ALU_B; ALU_Carry = (ALU_A >= ALU_B); end
         4'b0111: begin ALU_Result = (ALU_A < ALU_B) ? 33'd1 : 33'd0; ALU_Carry = 1'b0; end
         4'b1111: begin ALU_Result = (ALU_A == ALU_B) ? 33'd1 : 33'd0; ALU_Carry = 1'b0; end
         default: ;
      endcase
      ALU_Zero = (ALU_Result == '0);
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   typedef struct {
      logic [6:0]    op;
      logic [2:0]    f3;
      logic          f7;
      logic [DW-1:0] r1, r2, im;
   } stim_t;

   typedef struct {
      logic [DW-1:0] res;
      logic          zero, carry, taken, illegal;
      logic [3:0]    sel;
      logic [DW-1:0] a, b;
   } exp_t;

   localparam logic [DW-1:0] MSB = {1'b1, {(DW-1){1'b0}}};

   // Reference: what the op means, computed directly with signed/unsigned arithmetic
   function automatic exp_t ref_model(input stim_t s);
      exp_t          e;
      logic [DW-1:0] b;
      logic [DW:0]   sum;
      logic          lt, eq, ok;
      e.res = '0; e.zero = 1'b1; e.carry = 1'b0; e.taken = 1'b0; e.illegal = 1'b1;
      e.sel = 4'b0011; e.a = '0; e.b = '0;
      b   = (s.op == 7'b0010011) ? s.im : s.r2;
      lt  = ($signed(s.r1) < $signed(b));
      eq  = (s.r1 == s.r2);
      sum = {1'b0, s.r1} + {1'b0, b};
      ok  = 1'b1;
      if (s.op == 7'b0110011 || s.op == 7'b0010011) begin
         e.a = s.r1; e.b = b;
         case (s.f3)
            3'b000: begin
               if (s.op == 7'b0110011 && s.f7) begin
                  e.sel = 4'b0110; e.res = s.r1 - b; e.carry = (s.r1 >= b);
               end else begin
                  e.sel = 4'b0010; e.res = sum[DW-1:0]; e.carry = sum[DW];
               end
            end
            3'b111: begin e.sel = 4'b0000; e.res = s.r1 & b; end
            3'b110: begin e.sel = 4'b0001; e.res = s.r1 | b; end
            3'b010: begin
               e.sel = 4'b0111; e.res = lt ? 33'd1 : 33'd0;
               e.a = s.r1 ^ MSB; e.b = b ^ MSB;
            end
            default: ok = 1'b0;
         endcase
      end else if (s.op == 7'b1100011) begin
         e.a = s.r1; e.b = s.r2;
         case (s.f3)
            3'b000: begin e.sel = 4'b1111; e.res = eq ? 33'd1 : 33'd0; e.taken = eq;  end
            3'b001: begin e.sel = 4'b1111; e.res = eq ? 33'd1 : 33'd0; e.taken = !eq; end
            3'b100, 3'b101: begin
               e.sel = 4'b0111; e.res = lt ? 33'd1 : 33'd0;
               e.taken = (s.f3 == 3'b100) ? lt : !lt;
               e.a = s.r1 ^ MSB; e.b = s.r2 ^ MSB;
            end
            default: ok = 1'b0;
         endcase
      end else begin
         ok = 1'b0;
      end
      if (ok) begin
         e.illegal = 1'b0;
         e.zero    = (e.res == '0);
      end else begin
         e.res = '0; e.zero = 1'b1; e.carry = 1'b0; e.taken = 1'b0;
         e.sel = 4'b0011; e.a = '0; e.b = '0;
      end
      return e;
   endfunction

   function automatic logic [DW-1:0] rnd_val();
      logic [DW-1:0] v;
      case ($urandom_range(0, 4))
         0:       v = DW'($urandom_range(0, 8));
         1:       v = '0 - DW'($urandom_range(0, 8));
         2:       v = MSB;
         default: v = {1'($urandom_range(0, 1)), 32'($urandom())};
      endcase
      return v;
   endfunction

   function automatic stim_t rnd_stim();
      stim_t s;
      int    cat;
      cat  = $urandom_range(0, 9);
      s.f3 = 3'($urandom_range(0, 7));
      s.f7 = 1'($urandom_range(0, 1));
      s.r1 = rnd_val();
      s.r2 = ($urandom_range(0, 3) == 0) ? s.r1 : rnd_val();
      s.im = rnd_val();
      if (cat < 4) begin
         s.op = 7'b0110011;
         if ($urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 3))
               0: s.f3 = 3'b000;
               1: s.f3 = 3'b111;
               2: s.f3 = 3'b110;
               default: s.f3 = 3'b010;
            endcase
         end
      end else if (cat < 6) s.op = 7'b0010011;
      else if (cat < 9)     s.op = 7'b1100011;
      else                  s.op = 7'($urandom_range(0, 127));
      return s;
   endfunction

   function automatic stim_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input logic [DW-1:0] r1, input logic [DW-1:0] r2);
      stim_t s;
      s.op = op; s.f3 = f3; s.f7 = f7; s.r1 = r1; s.r2 = r2; s.im = '0;
      return s;
   endfunction

   // Model state: op on the ALU this cycle / result held this cycle
   exp_t          q[$];
   stim_t         plan[$];
   logic          m_issue, m_hold;
   logic [15:0]   m_count;
   logic [DW-1:0] m_a, m_b;
   logic [3:0]    m_sel;
   int            stall_left;

   task automatic run(input int ncyc);
      stim_t s;
      exp_t  e;
      logic  iv, from_plan, exp_rdy, accept, hs, nxt_hold;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         from_plan = (plan.size() > 0);
         if (from_plan) begin
            s  = plan[0];
            iv = 1'b1;
         end else begin
            s  = rnd_stim();
            iv = ($urandom_range(0, 9) < 7);
         end
         in_valid = iv; opcode = s.op; funct3 = s.f3; funct7_5 = s.f7;
         rs1_val = s.r1; rs2_val = s.r2; imm_val = s.im;
         if (from_plan) out_ready = 1'b1;
         else if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else if ($urandom_range(0, 7) == 0) begin
            out_ready  = 1'b0;
            stall_left = 5;
         end else out_ready = ($urandom_range(0, 3) != 0);
         #1;
         exp_rdy = !m_issue && (!m_hold || out_ready);
         check_val("in_ready", in_ready, exp_rdy);
         check_val("out_valid", out_valid, m_hold);
         check_val("op_count", op_count, m_count);
         check_val("alu_sel", ALU_Sel, m_sel);
         check_val("alu_a", ALU_A, m_a);
         check_val("alu_b", ALU_B, m_b);
         if (m_hold) begin
            if (q.size() == 0) check_val("queue_empty", 64'd1, 64'd0);
            else begin
               check_val("out_result", out_result, q[0].res);
               check_val("out_zero", out_zero, q[0].zero);
               check_val("out_carry", out_carry, q[0].carry);
               check_val("out_taken", out_taken, q[0].taken);
               check_val("out_illegal", out_illegal, q[0].illegal);
            end
         end
         accept = iv && exp_rdy;
         hs     = m_hold && out_ready;
         if (hs && q.size() > 0) void'(q.pop_front());
         if (accept) begin
            e = ref_model(s);
            q.push_back(e);
            m_count++;
            m_a = e.a; m_b = e.b; m_sel = e.sel;
            if (from_plan) void'(plan.pop_front());
         end
         nxt_hold = m_issue || (m_hold && !out_ready);
         m_issue  = accept;
         m_hold   = nxt_hold;
      end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      opcode = '0; funct3 = '0; funct7_5 = 1'b0;
      rs1_val = '0; rs2_val = '0; imm_val = '0;
      stall_left = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_val("rst_out_valid", out_valid, 1'b0);
      check_val("rst_in_ready", in_ready, 1'b1);
      check_val("rst_op_count", op_count, 16'd0);
      check_val("rst_alu_sel", ALU_Sel, 4'd0);
      check_val("rst_alu_a", ALU_A, '0);
      check_val("rst_out_result", out_result, '0);
      check_val("rst_out_zero", out_zero, 1'b0);
      check_val("rst_out_illegal", out_illegal, 1'b0);

      // Accept one ADD, then hit reset while it is on the ALU
      in_valid = 1'b1; opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0;
      rs1_val = 33'd5; rs2_val = 33'd3;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check_val("issue_alu_sel", ALU_Sel, 4'b0010);
      check_val("issue_op_count", op_count, 16'd1);
      check_val("issue_out_valid", out_valid, 1'b0);
      reset = 1'b1;
      #1;
      check_val("midrst_out_valid", out_valid, 1'b0);
      check_val("midrst_op_count", op_count, 16'd0);
      check_val("midrst_alu_sel", ALU_Sel, 4'd0);
      @(negedge clk);
      check_val("midrst_hold_valid", out_valid, 1'b0);
      reset = 1'b0;

      m_issue = 1'b0; m_hold = 1'b0; m_count = '0;
      m_a = '0; m_b = '0; m_sel = '0;
      plan.push_back(mk(7'b0110011, 3'b000, 1'b0, 33'd5, 33'd3));        // ADD
      plan.push_back(mk(7'b0110011, 3'b000, 1'b1, 33'd5, 33'd5));        // SUB
      plan.push_back(mk(7'b1100011, 3'b000, 1'b0, 33'd7, 33'd7));        // BEQ
      plan.push_back(mk(7'b1100011, 3'b100, 1'b0, '1, 33'd1));           // BLT
      plan.push_back(mk(7'b1100011, 3'b101, 1'b0, '1, 33'd1));           // BGE
      plan.push_back(mk(7'b0000000, 3'b000, 1'b0, 33'd9, 33'd4));        // illegal
      run(3000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
